// File: rtl/gppcu_sreg_unit.sv
// Status register stage: masked ALU flag latch, explicit writes, LIFO save stack, sticky V.
// Optional macro GPPCU_SREG_BYPASS_EN exposes the combinational next-SREG on oSREG_NEXT.
module gppcu_sreg_unit #(
  parameter int DEPTH  = 4,
  parameter int SREG_W = 5
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iSTALL,
  input  logic                         iALU_VALID,
  input  logic [3:0]                   iALU_FLAGS,
  input  logic [3:0]                   iFMASK,
  input  logic                         iWR_EN,
  input  logic [SREG_W-1:0]            iWR_DATA,
  input  logic                         iPUSH,
  input  logic                         iPOP,
  output logic [SREG_W-1:0]            oSREG,
  output logic [SREG_W-1:0]            oSREG_NEXT,
  output logic [$clog2(DEPTH+1)-1:0]   oDEPTH,
  output logic                         oFULL,
  output logic                         oEMPTY,
  output logic                         oERR
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam int SREG_Z  = 0;
  localparam int SREG_N  = 1;
  localparam int SREG_C  = 2;
  localparam int SREG_V  = 3;
  localparam int SREG_SV = 4;

  // Positions of each flag inside the 4-bit {V,C,N,Z} ALU/mask vectors
  localparam int F_Z = 0;
  localparam int F_N = 1;
  localparam int F_C = 2;
  localparam int F_V = 3;

  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [SREG_W-1:0] stack_q [DEPTH];
  logic [SREG_W-1:0] stack_d [DEPTH];

  logic [SREG_W-1:0] alu_sreg;
  logic              is_empty;
  logic              is_full;
  logic [CW-1:0]     cnt_m1;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_idx;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign cnt_m1   = cnt_q - CW'(1);
  assign top_idx  = cnt_m1[AW-1:0];
  assign wr_idx   = cnt_q[AW-1:0];

  // SV only ever sets here; clearing it takes a write or a pop
  always_comb begin
    alu_sreg          = sreg_q;
    alu_sreg[SREG_V]  = iFMASK[F_V] ? iALU_FLAGS[F_V] : sreg_q[SREG_V];
    alu_sreg[SREG_C]  = iFMASK[F_C] ? iALU_FLAGS[F_C] : sreg_q[SREG_C];
    alu_sreg[SREG_N]  = iFMASK[F_N] ? iALU_FLAGS[F_N] : sreg_q[SREG_N];
    alu_sreg[SREG_Z]  = iFMASK[F_Z] ? iALU_FLAGS[F_Z] : sreg_q[SREG_Z];
    alu_sreg[SREG_SV] = sreg_q[SREG_SV] | (iFMASK[F_V] & iALU_FLAGS[F_V]);
  end

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!iSTALL) begin
      if (iPUSH && iPOP && !is_empty) begin
        // Exchange: SREG and stack top swap, write/ALU ignored
        sreg_d           = stack_q[top_idx];
        stack_d[top_idx] = sreg_q;
      end else begin
        if (iPOP && !is_empty) begin
          sreg_d = stack_q[top_idx];
          cnt_d  = cnt_m1;
        end else if (iWR_EN) begin
          sreg_d = iWR_DATA;
        end else if (iALU_VALID) begin
          sreg_d = alu_sreg;
        end
        if (iPOP && is_empty && !iPUSH) begin
          err_d = 1'b1;
        end
        if (iPUSH) begin
          if (is_full) begin
            err_d = 1'b1;
          end else begin
            stack_d[wr_idx] = sreg_q;
            cnt_d           = cnt_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset term
  always_ff @(posedge iCLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign oSREG  = sreg_q;
  assign oDEPTH = cnt_q;
  assign oFULL  = is_full;
  assign oEMPTY = is_empty;
  assign oERR   = err_q;

`ifdef GPPCU_SREG_BYPASS_EN
  assign oSREG_NEXT = sreg_d;
`else
  assign oSREG_NEXT = sreg_q;
`endif

endmodule

// File: tb/tb_gppcu_sreg_unit.sv
// Directed table-driven bench for gppcu_sreg_unit (DEPTH=4, SREG = {SV,V,C,N,Z}).
module tb_gppcu_sreg_unit;

  logic       iCLK;
  logic       iRST_N;
  logic       iSTALL;
  logic       iALU_VALID;
  logic [3:0] iALU_FLAGS;
  logic [3:0] iFMASK;
  logic       iWR_EN;
  logic [4:0] iWR_DATA;
  logic       iPUSH;
  logic       iPOP;
  logic [4:0] oSREG;
  logic [4:0] oSREG_NEXT;
  logic [2:0] oDEPTH;
  logic       oFULL;
  logic       oEMPTY;
  logic       oERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stall;
    logic       alu_v;
    logic [3:0] flags;
    logic [3:0] fmask;
    logic       wr;
    logic [4:0] wdata;
    logic       push;
    logic       pop;
    logic [4:0] e_sreg;
    logic [2:0] e_depth;
    logic       e_err;
  } vec_t;

  vec_t vecA[$];
  vec_t vecB[$];

  gppcu_sreg_unit #(.DEPTH(4), .SREG_W(5)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iSTALL     (iSTALL),
    .iALU_VALID (iALU_VALID),
    .iALU_FLAGS (iALU_FLAGS),
    .iFMASK     (iFMASK),
    .iWR_EN     (iWR_EN),
    .iWR_DATA   (iWR_DATA),
    .iPUSH      (iPUSH),
    .iPOP       (iPOP),
    .oSREG      (oSREG),
    .oSREG_NEXT (oSREG_NEXT),
    .oDEPTH     (oDEPTH),
    .oFULL      (oFULL),
    .oEMPTY     (oEMPTY),
    .oERR       (oERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic vec_t mk(logic stall, logic alu_v, logic [3:0] flags, logic [3:0] fmask,
                              logic wr, logic [4:0] wdata, logic push, logic pop,
                              logic [4:0] e_sreg, logic [2:0] e_depth, logic e_err);
    vec_t v;
    v.stall = stall; v.alu_v = alu_v; v.flags = flags; v.fmask = fmask;
    v.wr = wr; v.wdata = wdata; v.push = push; v.pop = pop;
    v.e_sreg = e_sreg; v.e_depth = e_depth; v.e_err = e_err;
    return v;
  endfunction

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] e_sreg,
                             input logic [2:0] e_depth, input logic e_err);
    checkVal({tag, " sreg"},  32'(oSREG),  32'(e_sreg));
    checkVal({tag, " depth"}, 32'(oDEPTH), 32'(e_depth));
    checkVal({tag, " full"},  32'(oFULL),  32'(e_depth == 3'd4));
    checkVal({tag, " empty"}, 32'(oEMPTY), 32'(e_depth == 3'd0));
    checkVal({tag, " err"},   32'(oERR),   32'(e_err));
`ifndef GPPCU_SREG_BYPASS_EN
    checkVal({tag, " next"},  32'(oSREG_NEXT), 32'(e_sreg));
`endif
  endtask

  task automatic driveIdle();
    iSTALL = 0; iALU_VALID = 0; iALU_FLAGS = 0; iFMASK = 0;
    iWR_EN = 0; iWR_DATA = 0; iPUSH = 0; iPOP = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    iSTALL = v.stall; iALU_VALID = v.alu_v; iALU_FLAGS = v.flags; iFMASK = v.fmask;
    iWR_EN = v.wr; iWR_DATA = v.wdata; iPUSH = v.push; iPOP = v.pop;
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    // stall alu flags fmask wr wdata push pop | sreg depth err
    vecA.push_back(mk(0,1,4'b1010,4'b1111,0,5'h00,0,0, 5'h1A,3'd0,0));
    vecA.push_back(mk(0,1,4'b0001,4'b0001,0,5'h00,0,0, 5'h1B,3'd0,0));
    vecA.push_back(mk(0,1,4'b0000,4'b0001,0,5'h00,0,0, 5'h1A,3'd0,0));
    vecA.push_back(mk(0,1,4'b0000,4'b1111,0,5'h00,0,0, 5'h10,3'd0,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h00,0,0, 5'h00,3'd0,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h0A,0,0, 5'h0A,3'd0,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,1,0, 5'h0A,3'd1,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h05,1,0, 5'h05,3'd2,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h13,1,0, 5'h13,3'd3,0));
    vecA.push_back(mk(0,1,4'b0100,4'b0100,0,5'h00,1,0, 5'h17,3'd4,0));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h02,1,0, 5'h02,3'd4,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h13,3'd3,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h1F,1,1, 5'h05,3'd3,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h13,3'd2,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h1F,0,1, 5'h0A,3'd1,1));
    vecA.push_back(mk(0,1,4'b1111,4'b1111,0,5'h00,0,1, 5'h0A,3'd0,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h0A,3'd0,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h04,0,1, 5'h04,3'd0,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,1,5'h09,1,0, 5'h09,3'd1,1));
    for (int k = 0; k < 3; k++)
      vecA.push_back(mk(1,1,4'b1111,4'b1111,1,5'h1F,1,1, 5'h09,3'd1,1));
    vecA.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h04,3'd0,1));
    vecA.push_back(mk(1,1,4'b1111,4'b1111,1,5'h1F,0,1, 5'h04,3'd0,1));

    vecB.push_back(mk(0,0,4'b0000,4'b0000,1,5'h03,1,1, 5'h03,3'd1,0));
    vecB.push_back(mk(0,1,4'b1000,4'b1000,0,5'h00,0,0, 5'h1B,3'd1,0));
    vecB.push_back(mk(0,1,4'b0001,4'b0001,0,5'h00,1,1, 5'h00,3'd1,0));
    vecB.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h1B,3'd0,0));
    vecB.push_back(mk(0,0,4'b0000,4'b0000,0,5'h00,0,1, 5'h1B,3'd0,1));
    vecB.push_back(mk(0,0,4'b0000,4'b0000,1,5'h00,0,0, 5'h00,3'd0,1));
    vecB.push_back(mk(0,1,4'b1111,4'b0000,0,5'h00,0,0, 5'h00,3'd0,1));
    vecB.push_back(mk(0,1,4'b1111,4'b0110,0,5'h00,0,0, 5'h06,3'd0,1));

    driveIdle();
    iRST_N = 0;
    #2;
    checkOutput("reset", 5'h00, 3'd0, 1'b0);
    #5 iRST_N = 1;

    foreach (vecA[i]) begin
      applyStimulus(vecA[i]);
      checkOutput($sformatf("A%0d", i), vecA[i].e_sreg, vecA[i].e_depth, vecA[i].e_err);
    end

    // Asynchronous reset in the middle of a stalled request burst, between clock edges
    #3 iRST_N = 0;
    #1;
    checkOutput("async_reset", 5'h00, 3'd0, 1'b0);
    driveIdle();
    #2 iRST_N = 1;

    foreach (vecB[i]) begin
      applyStimulus(vecB[i]);
      checkOutput($sformatf("B%0d", i), vecB[i].e_sreg, vecB[i].e_depth, vecB[i].e_err);
    end

`ifdef GPPCU_SREG_BYPASS_EN
    iALU_VALID = 1; iALU_FLAGS = 4'b0001; iFMASK = 4'b0001;
    #1;
    checkVal("bypass next_same_cycle", 32'(oSREG_NEXT), 32'h07);
    checkVal("bypass sreg_same_cycle", 32'(oSREG), 32'h06);
    iSTALL = 1;
    #1;
    checkVal("bypass next_stalled", 32'(oSREG_NEXT), 32'h06);
    iSTALL = 0;
    @(posedge iCLK);
    #1;
    checkVal("bypass sreg_next_cycle", 32'(oSREG), 32'h07);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
